// File: rtl/leb128_pkg.sv
// Shared LEB128 definitions: sizes, writer FSM state encoding and the
// minimal-length helper used by both the writer and the parser-side checks.
package leb128_pkg;

    localparam int LEB128_MAX_BYTES = 8;
    localparam int LEB128_DATA_W    = 56;

    typedef enum logic [0:0] {
        LEB128_WR_IDLE = 1'b0,
        LEB128_WR_EMIT = 1'b1
    } leb128_wr_state_e;

    // Number of bytes a minimal encoding needs: index of the highest
    // non-zero 7-bit group plus one, never less than one (value 0 -> 1).
    function automatic logic [3:0] leb128_min_len(input logic [LEB128_DATA_W-1:0] value);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 1; i < LEB128_MAX_BYTES; i++) begin
            if (value[i*7 +: 7] != 7'd0) begin
                n = 4'(i + 1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/leb128_writer_if.sv
// Bundle of the value-in and byte-out handshakes of the LEB128 writer.
// master: the side feeding values and consuming bytes; slave: the writer.
interface leb128_writer_if
    import leb128_pkg::*;
#(
    parameter int DATA_W = LEB128_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_value;
    logic [3:0]        in_pad_len;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              done;
    logic [3:0]        out_len;
    logic              len_err;

    modport master (
        output in_valid, in_value, in_pad_len, out_ready,
        input  in_ready, out_byte, out_valid, out_last, done, out_len, len_err
    );

    modport slave (
        input  in_valid, in_value, in_pad_len, out_ready,
        output in_ready, out_byte, out_valid, out_last, done, out_len, len_err
    );
endinterface

// File: rtl/leb128_writer.sv
// Serialises an unsigned value into an AV1 leb128() byte stream, least
// significant 7-bit group first, optionally zero-padded to a fixed length.
module leb128_writer
    import leb128_pkg::*;
#(
    parameter int DATA_W    = LEB128_DATA_W,
    parameter int MAX_BYTES = LEB128_MAX_BYTES
) (
    input  logic           clk,
    input  logic           rst,
    leb128_writer_if.slave bus
);

    leb128_wr_state_e  state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [3:0]        rem_q, rem_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_pend_q, err_pend_d;
    logic              done_q, done_d;
    logic [3:0]        out_len_q, out_len_d;
    logic              len_err_q, len_err_d;

    logic [3:0]        min_len;
    logic [3:0]        req_len;
    logic [3:0]        enc_len;
    logic              enc_err;
    logic              accept;
    logic              byte_xfer;
    logic              last_xfer;

    // Length selection for the value currently offered on the input.
    always_comb begin
        min_len = leb128_min_len(bus.in_value);
        req_len = (bus.in_pad_len > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : bus.in_pad_len;
        enc_err = (req_len != 4'd0) && (req_len < min_len);
        enc_len = ((req_len == 4'd0) || (req_len < min_len)) ? min_len : req_len;
    end

    // Handshake qualifiers, all gated by the registered state.
    always_comb begin
        accept    = (state_q == LEB128_WR_IDLE) && bus.in_valid;
        byte_xfer = (state_q == LEB128_WR_EMIT) && bus.out_ready;
        last_xfer = byte_xfer && (rem_q == 4'd1);
    end

    // FSM state register; reset drops any partial encoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LEB128_WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one value per IDLE visit, leave EMIT on the last byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LEB128_WR_IDLE: if (accept)    state_d = LEB128_WR_EMIT;
            LEB128_WR_EMIT: if (last_xfer) state_d = LEB128_WR_IDLE;
            default:                       state_d = LEB128_WR_IDLE;
        endcase
    end

    // FSM outputs decoded from registered state only (no in/out ready paths).
    always_comb begin
        bus.in_ready  = (state_q == LEB128_WR_IDLE);
        bus.out_valid = (state_q == LEB128_WR_EMIT);
        bus.out_last  = (state_q == LEB128_WR_EMIT) && (rem_q == 4'd1);
        bus.out_byte  = 8'h00;
        if (state_q == LEB128_WR_EMIT) begin
            bus.out_byte = {rem_q != 4'd1, shreg_q[6:0]};
        end
    end

    // Counters, status latches and the shift register's next values.
    always_comb begin
        shreg_d    = shreg_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        done_d     = 1'b0;
        out_len_d  = out_len_q;
        len_err_d  = len_err_q;
        if (accept) begin
            shreg_d    = bus.in_value;
            rem_d      = enc_len;
            cnt_d      = 4'd0;
            err_pend_d = enc_err;
        end else if (byte_xfer) begin
            // Zero fill makes exhausted groups emit as 0x80 / final 0x00 padding.
            shreg_d = shreg_q >> 7;
            rem_d   = rem_q - 4'd1;
            cnt_d   = cnt_q + 4'd1;
            if (rem_q == 4'd1) begin
                done_d    = 1'b1;
                out_len_d = cnt_q + 4'd1;
                len_err_d = err_pend_q;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q      <= 4'd0;
            cnt_q      <= 4'd0;
            err_pend_q <= 1'b0;
            done_q     <= 1'b0;
            out_len_q  <= 4'd0;
            len_err_q  <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            done_q     <= done_d;
            out_len_q  <= out_len_d;
            len_err_q  <= len_err_d;
        end
    end

    // Value shift register; only observed in EMIT, so it needs no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign bus.done    = done_q;
    assign bus.out_len = out_len_q;
    assign bus.len_err = len_err_q;

endmodule

// File: tb/tb_leb128_writer.sv
// Randomised scoreboard bench for leb128_writer: expected bytes and done
// records are queued when a value is issued and popped by a monitor.
module tb_leb128_writer;
    import leb128_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    leb128_writer_if #(.DATA_W(56)) bus();

    leb128_writer #(.DATA_W(56), .MAX_BYTES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       last;
        logic [7:0] b;
    } exp_byte_t;

    typedef struct packed {
        logic [3:0] len;
        logic       err;
    } exp_done_t;

    exp_byte_t exp_q[$];
    exp_done_t done_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int accepted = 0;
    bit rmode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: leb128() from plain arithmetic, padded with continuation bytes.
    function automatic int model(input longint unsigned v, input int pad);
        int req, minl, len;
        longint unsigned t;
        exp_byte_t e;
        exp_done_t d;
        req  = (pad > 8) ? 8 : pad;
        minl = 1;
        t    = v / 128;
        while (t != 0) begin
            minl++;
            t = t / 128;
        end
        len = (req == 0 || req < minl) ? minl : req;
        for (int k = 0; k < len; k++) begin
            e.b    = 8'((v / (64'd1 << (7 * k))) % 128);
            e.last = (k == len - 1);
            if (k != len - 1) e.b = e.b + 8'd128;
            exp_q.push_back(e);
        end
        d.len = 4'(len);
        d.err = (req != 0 && req < minl);
        done_q.push_back(d);
        return len;
    endfunction

    // Downstream ready: always high, or random per cycle when rmode is set.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expectations on each accepted byte and each done pulse.
    initial begin
        exp_byte_t  e;
        exp_done_t  d;
        logic       held_v;
        logic [7:0] held_b;
        logic       held_l;
        held_v = 1'b0;
        held_b = 8'h00;
        held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) check("stall_valid", bus.out_valid, 1);
                if (bus.out_valid) begin
                    check("in_ready_busy", bus.in_ready, 0);
                    if (held_v) begin
                        check("stall_byte", bus.out_byte, held_b);
                        check("stall_last", bus.out_last, held_l);
                    end
                    if (bus.out_ready) begin
                        held_v = 1'b0;
                        accepted++;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_byte: got 0x%0h, expected none", bus.out_byte);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_byte", bus.out_byte, e.b);
                            check("out_last", bus.out_last, e.last);
                        end
                    end else begin
                        held_v = 1'b1;
                        held_b = bus.out_byte;
                        held_l = bus.out_last;
                    end
                end else begin
                    held_v = 1'b0;
                end
                if (bus.done) begin
                    if (done_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: got out_len %0d, expected no done", bus.out_len);
                    end else begin
                        d = done_q.pop_front();
                        check("out_len", bus.out_len, d.len);
                        check("len_err", bus.len_err, d.err);
                    end
                end
            end
        end
    end

    // Issue one value and wait for its done pulse (bounded).
    task automatic send(input longint unsigned v, input int pad);
        int  len;
        int  k;
        bit  got;
        @(posedge clk);
        #1;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        len = model(v, pad);
        bus.in_valid   = 1'b1;
        bus.in_value   = v[55:0];
        bus.in_pad_len = 4'(pad);
        @(posedge clk);
        #1;
        // Keep presenting a different value while busy; it must be ignored.
        bus.in_value = ~v[55:0];
        got = 1'b0;
        for (k = 1; k <= 300 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("first_byte_latency", bus.out_valid, 1);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
            end else if (bus.done) begin
                got = 1'b1;
                check("in_ready_at_done", bus.in_ready, 1);
                if (!rmode) check("done_cycle", 64'(k), 64'(len + 1));
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done, expected one within 300 cycles");
        end
    endtask

    initial begin
        int base;
        int k;
        longint unsigned v;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_value   = '0;
        bus.in_pad_len = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_byte", bus.out_byte, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_out_len", bus.out_len, 0);
        check("rst_len_err", bus.len_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(64'd0, 0);
        send(64'd300, 0);
        send(64'd5, 8);
        send(64'h00FF_FFFF_FFFF_FFFF, 0);
        send(64'h00FF_FFFF_FFFF_FFFF, 15);
        rmode = 1'b1;
        send(64'd624485, 0);
        rmode = 1'b0;
        send(64'd300, 1);

        // Reset after the first byte of a three-byte encoding.
        @(posedge clk);
        #1;
        base = accepted;
        void'(model(64'd624485, 0));
        bus.in_valid   = 1'b1;
        bus.in_value   = 56'd624485;
        bus.in_pad_len = 4'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        k = 0;
        while (accepted == base && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_rst_first_byte_seen", 64'(accepted - base), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_len", bus.out_len, 0);
        check("mid_rst_len_err", bus.len_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        send(64'd624485, 0);

        // Randomised values, pad lengths and downstream backpressure.
        for (int i = 0; i < 40; i++) begin
            v = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
            v = v & 64'h00FF_FFFF_FFFF_FFFF;
            rmode = 1'($urandom_range(0, 1));
            send(v, int'($urandom_range(0, 15)));
        end
        rmode = 1'b0;

        repeat (5) @(posedge clk);
        check("byte_queue_drained", 64'(exp_q.size()), 0);
        check("done_queue_drained", 64'(done_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
